dmi_req_queue: RTL and testbench

//  Core-clock stage between dmi_wrapper's core-side outputs and the debug module register file.
//  - Queues DMI read/write requests (reg_en/reg_wr_en pulses) in a small FIFO.
//  - Issues one request at a time to the debug module over a valid/ready handshake.
//  - Returns the response to dmi_wrapper as rd_data plus a one-cycle reg_ack.

---
 rtl/dmi_req_queue_if.sv | 44 ++++
 rtl/dmi_req_queue.sv | 160 ++++++++++++++++
 tb/tb_dmi_req_queue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_req_queue_if.sv
// ============================================================================
//  Module      : dmi_req_queue_if
//  Description : Bundles the dmi_wrapper request/response signals and the
//                debug-module request/response bus used by dmi_req_queue.
//                master = queue side, slave = environment side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmi_req_queue_if #(
  parameter int ADDR_W = 7
);
  // dmi_wrapper side
  logic              reg_en;
  logic              reg_wr_en;
  logic [31:0]       reg_wr_addr;
  logic [31:0]       reg_wr_data;
  logic [31:0]       rd_data;
  logic              reg_ack;
  // debug module side
  logic              dm_req_valid;
  logic              dm_req_ready;
  logic              dm_req_wr;
  logic [ADDR_W-1:0] dm_req_addr;
  logic [31:0]       dm_req_wdata;
  logic              dm_rsp_valid;
  logic [31:0]       dm_rsp_rdata;

  modport master (
    input  reg_en, reg_wr_en, reg_wr_addr, reg_wr_data,
    output rd_data, reg_ack,
    output dm_req_valid, dm_req_wr, dm_req_addr, dm_req_wdata,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata
  );

  modport slave (
    output reg_en, reg_wr_en, reg_wr_addr, reg_wr_data,
    input  rd_data, reg_ack,
    input  dm_req_valid, dm_req_wr, dm_req_addr, dm_req_wdata,
    output dm_req_ready, dm_rsp_valid, dm_rsp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmi_req_queue.sv
// ============================================================================
//  Module      : dmi_req_queue
//  Description : Core-clock request queue between dmi_wrapper and the debug
//                module. Buffers DMI requests in a small FIFO, issues them one
//                at a time over valid/ready, and returns rd_data + reg_ack.
//                Optional response timeout: define DMI_REQ_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmi_req_queue #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   core_clk,
  input  logic                   core_rst,
  dmi_req_queue_if.master        bus,
  input  logic                   err_clr,
  output logic                   ovf_err,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef DMI_REQ_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + ADDR_W + 32;   // {wr, addr, data}

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;
  localparam logic [1:0] ACK      = 2'd3;

  logic [1:0]         state;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               drop;
  logic               rsp_is_wr;
  logic [31:0]        rd_data_q;
  logic               rsp_timeout;
  logic               unused_addr_hi;

  // Only the low ADDR_W address bits are forwarded to the debug module.
  assign unused_addr_hi = ^bus.reg_wr_addr[31:ADDR_W];

  assign head       = mem[rd_ptr];
  assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign pop        = (state == ISSUE) && bus.dm_req_ready;
  assign push       = bus.reg_en && (!fifo_full || pop);
  assign drop       = bus.reg_en && fifo_full && !pop;

  // Request fields are only driven while valid so idle outputs read as zero.
  assign bus.dm_req_valid = (state == ISSUE);
  assign bus.dm_req_wr    = (state == ISSUE) && head[ENTRY_W-1];
  assign bus.dm_req_addr  = (state == ISSUE) ? head[ENTRY_W-2:32] : '0;
  assign bus.dm_req_wdata = (state == ISSUE) ? head[31:0] : '0;
  assign bus.reg_ack      = (state == ACK);
  assign bus.rd_data      = rd_data_q;
  assign fifo_level       = count;

  // FIFO storage; entries need no reset because reads are gated by count.
  always_ff @(posedge core_clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.reg_wr_en, bus.reg_wr_addr[ADDR_W-1:0], bus.reg_wr_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as err_clr keeps it set.
  always_ff @(posedge core_clk) begin
    if (core_rst)     ovf_err <= 1'b0;
    else if (drop)    ovf_err <= 1'b1;
    else if (err_clr) ovf_err <= 1'b0;
  end

`ifdef DMI_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] wait_cnt;

  // Counts cycles spent in WAIT_RSP; restarts from zero on every entry.
  always_ff @(posedge core_clk) begin
    if (core_rst || state != WAIT_RSP) wait_cnt <= '0;
    else                               wait_cnt <= wait_cnt + 1'b1;
  end

  assign rsp_timeout = (state == WAIT_RSP) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Sticky timeout flag; a real response in the expiry cycle suppresses it.
  always_ff @(posedge core_clk) begin
    if (core_rst)                                timeout_err <= 1'b0;
    else if (rsp_timeout && !bus.dm_rsp_valid)   timeout_err <= 1'b1;
    else if (err_clr)                            timeout_err <= 1'b0;
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign rsp_timeout = 1'b0;
`endif

  // Request sequencer: one outstanding request, responses returned in order.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state     <= IDLE;
      rsp_is_wr <= 1'b0;
      rd_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= ISSUE;
        end
        ISSUE: begin
          if (bus.dm_req_ready) begin
            rsp_is_wr <= head[ENTRY_W-1];
            state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus.dm_rsp_valid) begin
            rd_data_q <= rsp_is_wr ? 32'h0 : bus.dm_rsp_rdata;
            state     <= ACK;
          end else if (rsp_timeout) begin
            rd_data_q <= 32'hFFFF_FFFF;
            state     <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmi_req_queue.sv
// ============================================================================
//  Module      : tb_dmi_req_queue
//  Description : Randomized self-checking bench for dmi_req_queue with a
//                queue-based reference model and a reactive debug-module
//                responder. Timeout checks compile in with DMI_REQ_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmi_req_queue;
  localparam int DEPTH       = 4;
  localparam int ADDR_W      = 7;
  localparam int TIMEOUT_CYC = 16;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } req_t;

  logic                   core_clk = 1'b0;
  logic                   core_rst = 1'b1;
  logic                   err_clr  = 1'b0;
  logic                   ovf_err;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef DMI_REQ_TIMEOUT_EN
  logic                   timeout_err;
`endif

  dmi_req_queue_if #(.ADDR_W(ADDR_W)) bus ();

  dmi_req_queue #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .core_clk    (core_clk),
    .core_rst    (core_rst),
    .bus         (bus),
    .err_clr     (err_clr),
    .ovf_err     (ovf_err),
    .fifo_level  (fifo_level)
`ifdef DMI_REQ_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 core_clk = ~core_clk;

  // Reference model state
  req_t        q[$];
  int          cyc      = 0;
  bit          waiting  = 0;
  bit          wait_wr  = 0;
  int          rsp_cnt  = 0;
  int          wait_n   = 0;
  int          ack_due  = -1;
  logic [31:0] last_rd  = '0;
  bit          m_ovf    = 0;
  bit          m_to     = 0;
  int          fixed_delay = 0;
  bit          use_fix  = 0;
  logic [31:0] rsp_fix  = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance it.
  task automatic step(input bit en, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input bit rdy, input bit clr, input bit spur);
    bit          rv;
    bit          pop;
    bit          ovf_set;
    bit          to_set;
    logic [31:0] rd;
    req_t        r;
    @(negedge core_clk);
    rd = use_fix ? rsp_fix : $urandom();
    rv = 1'b0;
    if (waiting) begin
      if (rsp_cnt <= 1) rv = 1'b1;
      else              rsp_cnt--;
    end else begin
      rv = spur;
    end
    bus.reg_en       = en;
    bus.reg_wr_en    = wr;
    bus.reg_wr_addr  = addr;
    bus.reg_wr_data  = data;
    bus.dm_req_ready = rdy;
    bus.dm_rsp_valid = rv;
    bus.dm_rsp_rdata = rd;
    err_clr          = clr;
    #1;
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("ovf_err", 32'(ovf_err), 32'(m_ovf));
    check("reg_ack", 32'(bus.reg_ack), 32'(cyc == ack_due));
    check("rd_data", bus.rd_data, last_rd);
`ifdef DMI_REQ_TIMEOUT_EN
    check("timeout_err", 32'(timeout_err), 32'(m_to));
`endif
    if (bus.dm_req_valid) begin
      check("one_outstanding", 32'(waiting || ack_due == cyc), 32'd0);
      check("valid_with_entry", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        check("req_wr", 32'(bus.dm_req_wr), 32'(q[0].wr));
        check("req_addr", 32'(bus.dm_req_addr), 32'(q[0].addr));
        check("req_wdata", bus.dm_req_wdata, q[0].data);
      end
    end
    // response / timeout bookkeeping
    to_set = 1'b0;
    if (waiting) begin
      if (rv) begin
        last_rd = wait_wr ? 32'h0 : rd;
        ack_due = cyc + 1;
        waiting = 0;
      end
`ifdef DMI_REQ_TIMEOUT_EN
      else if (wait_n == TIMEOUT_CYC - 1) begin
        last_rd = 32'hFFFF_FFFF;
        ack_due = cyc + 1;
        waiting = 0;
        to_set  = 1'b1;
      end else begin
        wait_n++;
      end
`endif
    end
    // handshake, then push (a same-cycle pop frees a slot)
    pop = bus.dm_req_valid && rdy && (q.size() != 0);
    if (pop) begin
      wait_wr = q[0].wr;
      void'(q.pop_front());
      waiting = 1;
      wait_n  = 0;
      rsp_cnt = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 4));
    end
    ovf_set = 1'b0;
    if (en) begin
      if (q.size() < DEPTH) begin
        r.wr = wr; r.addr = addr[ADDR_W-1:0]; r.data = data;
        q.push_back(r);
      end else begin
        ovf_set = 1'b1;
      end
    end
    if (ovf_set)  m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (to_set)   m_to = 1;
    else if (clr) m_to = 0;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy, 0, 0);
  endtask

  // Run with ready high until all queued work and acknowledgements are done.
  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (q.size() == 0 && !waiting && ack_due < cyc) break;
      step(0, 0, 0, 0, 1, 0, 0);
    end
    check("drain_done", 32'(q.size()) + 32'(waiting) + 32'(ack_due >= cyc), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge core_clk);
    core_rst = 1'b1;
    bus.reg_en = 0; bus.dm_req_ready = 0; bus.dm_rsp_valid = 0; err_clr = 0;
    @(negedge core_clk);
    @(negedge core_clk);
    #1;
    check("rst_valid", 32'(bus.dm_req_valid), 0);
    check("rst_wr", 32'(bus.dm_req_wr), 0);
    check("rst_addr", 32'(bus.dm_req_addr), 0);
    check("rst_wdata", bus.dm_req_wdata, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_ack", 32'(bus.reg_ack), 0);
    check("rst_ovf", 32'(ovf_err), 0);
    check("rst_level", 32'(fifo_level), 0);
`ifdef DMI_REQ_TIMEOUT_EN
    check("rst_timeout_err", 32'(timeout_err), 0);
`endif
    core_rst = 1'b0;
    q.delete();
    waiting = 0; ack_due = -1; last_rd = '0; m_ovf = 0; m_to = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    bus.reg_en = 0; bus.reg_wr_en = 0; bus.reg_wr_addr = 0; bus.reg_wr_data = 0;
    bus.dm_req_ready = 0; bus.dm_rsp_valid = 0; bus.dm_rsp_rdata = 0;
    do_reset();

    // Read 0x11 at minimum latency: reg_en at N -> reg_ack at N+4
    fixed_delay = 1; use_fix = 1; rsp_fix = 32'h0040_0382;
    n0 = cyc;
    step(1, 0, 32'hABCD_0011, $urandom(), 1, 0, 0);
    for (int i = 0; i < 10 && ack_due < 0; i++) step(0, 0, 0, 0, 1, 0, 0);
    check("latency", 32'(ack_due - n0), 32'd4);
    wait_done(20);
    check("t1_rd_data", bus.rd_data, 32'h0040_0382);
    use_fix = 0;

    // Write held off by ready low; fields checked stable every cycle
    step(1, 1, 32'h0000_0010, 32'h8000_0001, 0, 0, 0);
    idle(7, 0);
    wait_done(20);
    check("t2_rd_data", bus.rd_data, 32'h0);

    // Five back-to-back requests into a 4-deep FIFO with ready low
    fixed_delay = 0;
    for (int i = 0; i < 5; i++) step(1, i[0], $urandom(), $urandom(), 0, 0, 0);
    idle(1, 0);
    check("t3_level", 32'(fifo_level), 32'd4);
    check("t3_ovf", 32'(ovf_err), 32'd1);
    wait_done(60);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(1, 0);
    check("t3_ovf_cleared", 32'(ovf_err), 32'd0);

    // Push while full in the same cycle as a pop
    for (int i = 0; i < 4; i++) step(1, 0, $urandom(), $urandom(), 0, 0, 0);
    idle(2, 0);
    step(1, 1, $urandom(), $urandom(), 1, 0, 0);
    idle(1, 0);
    check("t5_level", 32'(fifo_level), 32'd4);
    check("t5_ovf", 32'(ovf_err), 32'd0);
    wait_done(60);

    // Reset while waiting for a response, then a late response
    fixed_delay = 10;
    step(1, 0, $urandom(), $urandom(), 1, 0, 0);
    for (int i = 0; i < 10 && !waiting; i++) step(0, 0, 0, 0, 1, 0, 0);
    check("t4_in_wait", 32'(waiting), 32'd1);
    idle(2, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 1);

`ifdef DMI_REQ_TIMEOUT_EN
    // Read with no response until the timeout expires
    fixed_delay = 1000;
    step(1, 0, $urandom(), $urandom(), 1, 0, 0);
    for (int i = 0; i < 40 && ack_due < 0; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("t6_rd_data", bus.rd_data, 32'hFFFF_FFFF);
    check("t6_timeout_err", 32'(timeout_err), 32'd1);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(1, 0);
`endif

    // Randomized traffic
    fixed_delay = 0;
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 4, $urandom_range(0, 1), $urandom(), $urandom(),
           $urandom_range(0, 1), $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
    end
    wait_done(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
